// File: rtl/branch_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// branch_hazard_ctrl
//   ID-stage branch resolution and hazard control for the 5-stage MIPS
//   pipeline. Classifies data hazards on the branch source registers and
//   stalls the front end until they clear. It then drives the select lines
//   of forwarding_mux_beq, compares the forwarded operands, and resolves
//   beq/bne, flushing IF/ID when the branch is taken. It also keeps
//   saturating statistics counters for stall cycles and taken branches.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   id_beq, id_bne        ID instruction is beq / bne (both set => beq)
//   id_rs, id_rt          ID source register numbers
//   ex_reg_write, ex_mem_read, ex_rd     EX-stage writer/load info
//   mem_reg_write, mem_mem_read, mem_rd  MEM-stage writer/load info
//   rs_val, rt_val        operands returned from forwarding_mux_beq
//   fwd_sel_rs/rt         mux selects (0 = regfile, 1 = EX/MEM)
//   stall                 hold PC and IF/ID
//   id_ex_bubble          zero ID/EX control signals
//   branch_taken          PC source = branch target
//   if_id_flush           squash the instruction in IF/ID
//   stall_count           saturating count of stall cycles
//   taken_count           saturating count of taken branches
// ---------------------------------------------------------------------------
module branch_hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_beq,
  input  logic             id_bne,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_reg_write,
  input  logic             mem_mem_read,
  input  logic [4:0]       mem_rd,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  output logic [1:0]       fwd_sel_rs,
  output logic [1:0]       fwd_sel_rt,
  output logic             stall,
  output logic             id_ex_bubble,
  output logic             branch_taken,
  output logic             if_id_flush,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } state_t;

  state_t     state, state_next;
  logic [1:0] cnt, cnt_next;

  logic       br;
  logic       rs_used, rt_used;
  logic       rs_h2, rt_h2;
  logic       rs_h1, rt_h1;
  logic       rs_fw, rt_fw;
  logic [1:0] need;
  logic       operands_eq;

  logic       stall_c, bubble_c, taken_c;
  logic [1:0] sel_rs_c, sel_rt_c;

  assign br      = id_beq | id_bne;
  // $0 is hard-wired to zero, so it can never carry a hazard.
  assign rs_used = br & (id_rs != 5'd0);
  assign rt_used = br & (id_rt != 5'd0);

  // A load in EX is two cycles away from its data; an ALU result in EX or a
  // load in MEM is one cycle away; an ALU result in MEM can be forwarded now.
  assign rs_h2 = rs_used & ex_mem_read & (ex_rd == id_rs);
  assign rt_h2 = rt_used & ex_mem_read & (ex_rd == id_rt);
  assign rs_h1 = rs_used & ((ex_reg_write & ~ex_mem_read & (ex_rd == id_rs)) |
                            (mem_mem_read & (mem_rd == id_rs)));
  assign rt_h1 = rt_used & ((ex_reg_write & ~ex_mem_read & (ex_rd == id_rt)) |
                            (mem_mem_read & (mem_rd == id_rt)));
  assign rs_fw = rs_used & mem_reg_write & ~mem_mem_read & (mem_rd == id_rs);
  assign rt_fw = rt_used & mem_reg_write & ~mem_mem_read & (mem_rd == id_rt);

  always_comb begin
    need = 2'd0;
    if (rs_h2 | rt_h2) begin
      need = 2'd2;
    end else if (rs_h1 | rt_h1) begin
      need = 2'd1;
    end
  end

  assign operands_eq = (rs_val == rt_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // WAIT holds the pipeline for the remaining counted stall cycles without
  // looking at the hazard inputs again; IDLE either starts a stall or
  // resolves the branch in the same cycle.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall_c    = 1'b0;
    bubble_c   = 1'b0;
    taken_c    = 1'b0;
    sel_rs_c   = 2'd0;
    sel_rt_c   = 2'd0;
    case (state)
      ST_IDLE: begin
        if (br) begin
          if (need != 2'd0) begin
            stall_c    = 1'b1;
            bubble_c   = 1'b1;
            cnt_next   = need - 2'd1;
            state_next = (need == 2'd2) ? ST_WAIT : ST_IDLE;
          end else begin
            sel_rs_c = {1'b0, rs_fw};
            sel_rt_c = {1'b0, rt_fw};
            taken_c  = id_beq ? operands_eq : (id_bne & ~operands_eq);
          end
        end
      end
      ST_WAIT: begin
        stall_c  = 1'b1;
        bubble_c = 1'b1;
        cnt_next = (cnt == 2'd0) ? 2'd0 : cnt - 2'd1;
        if (cnt_next == 2'd0) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 2'd0;
      end
    endcase
  end

  // All control outputs read as zero for as long as reset is held.
  assign stall        = rst_n & stall_c;
  assign id_ex_bubble = rst_n & bubble_c;
  assign branch_taken = rst_n & taken_c;
  assign if_id_flush  = rst_n & taken_c;
  assign fwd_sel_rs   = sel_rs_c & {2{rst_n}};
  assign fwd_sel_rt   = sel_rt_c & {2{rst_n}};

  // Statistics counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
      taken_count <= '0;
    end else begin
      if (stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end
      if (branch_taken && (taken_count != {CNT_W{1'b1}})) begin
        taken_count <= taken_count + 1'b1;
      end
    end
  end

endmodule
